// File: rtl/axi_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_if
// Brief    : AW/W/B and AR/R signal bundle between a 40-bit AXI initiator
//            and the axi_mem_responder memory model.
// Revision : 1.0
// ============================================================================
interface axi_mem_if #(
    parameter int DATA_WIDTH = 256
) ();
    logic [39:0]           axi_awaddr;
    logic [7:0]            axi_awlen;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic                  axi_wlast;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [39:0]           axi_araddr;
    logic [7:0]            axi_arlen;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic                  axi_rlast;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport master (
        output axi_awaddr, axi_awlen, axi_awvalid,
        output axi_wdata, axi_wlast, axi_wvalid,
        output axi_bready,
        output axi_araddr, axi_arlen, axi_arvalid,
        output axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
        input  axi_arready, axi_rdata, axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_wdata, axi_wlast, axi_wvalid,
        input  axi_bready,
        input  axi_araddr, axi_arlen, axi_arvalid,
        input  axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
        output axi_arready, axi_rdata, axi_rlast, axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder
// Brief    : AXI4 INCR-burst memory responder with independent read and write
//            channel FSMs over a DEPTH x DATA_WIDTH word array.
// Revision : 1.0
// ============================================================================
module axi_mem_responder #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 256,
    parameter int READ_LAT   = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    axi_mem_if.slave     bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [39:0] IDX_MASK = 40'(DEPTH - 1) << OFF_W;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    w_state_t              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [IDX_W-1:0]      w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_beat_q, w_beat_d;
    logic                  w_err_q, w_err_d;
    logic                  mem_we;

    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic [CNT_W-1:0]      r_cnt_q, r_cnt_d;

    // Address bits outside the word index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.axi_awaddr & ~IDX_MASK, bus.axi_araddr & ~IDX_MASK};

    // ---------------------------------------------------------------- write
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (bus.axi_awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_idx_d   = bus.axi_awaddr[OFF_W +: IDX_W];
                    w_len_d   = bus.axi_awlen;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.axi_wvalid && wready_q) begin
                    mem_we   = 1'b1;
                    w_idx_d  = w_idx_q + IDX_W'(1);
                    w_beat_d = w_beat_q + 8'd1;
                    // Beat count, not wlast, terminates the burst; wlast only grades it.
                    if (w_beat_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || !bus.axi_wlast) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else if (bus.axi_wlast) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bus.axi_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_beat_q  <= 8'd0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    // Storage survives reset so a bench can reset the port and read back.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[w_idx_q] <= bus.axi_wdata;
        end
    end

    // ----------------------------------------------------------------- read
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    r_idx_d   = bus.axi_araddr[OFF_W +: IDX_W];
                    r_len_d   = bus.axi_arlen;
                    r_beat_d  = 8'd0;
                    if (READ_LAT == 0) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = mem_q[bus.axi_araddr[OFF_W +: IDX_W]];
                        rlast_d   = (bus.axi_arlen == 8'd0);
                        r_state_d = R_DATA;
                    end else begin
                        r_cnt_d   = CNT_W'(READ_LAT - 1);
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = mem_q[r_idx_q];
                    rlast_d   = (r_len_q == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            R_DATA: begin
                if (rvalid_q && bus.axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d  = r_idx_q + IDX_W'(1);
                        r_beat_d = r_beat_q + 8'd1;
                        rdata_d  = mem_q[r_idx_q + IDX_W'(1)];
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign bus.axi_awready = awready_q;
    assign bus.axi_wready  = wready_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.axi_arready = arready_q;
    assign bus.axi_rvalid  = rvalid_q;
    assign bus.axi_rlast   = rlast_q;
    assign bus.axi_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_responder
// Brief    : Randomized bench for axi_mem_responder against an array model.
// Revision : 1.0
// ============================================================================
module tb_axi_mem_responder;
    localparam int DW       = 256;
    localparam int DEPTH    = 256;
    localparam int READ_LAT = 2;
    localparam int OFF      = $clog2(DW / 8);
    localparam int TIMEOUT  = 200;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [256];

    axi_mem_if #(.DATA_WIDTH(DW)) bus ();

    axi_mem_responder #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int addr_idx(input logic [39:0] addr);
        return int'((addr >> OFF) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // bad_last: -1 wlast on final beat only, -2 never, k>=0 only on beat k.
    task automatic do_write(input logic [39:0] addr, input int len, input int bad_last,
                            input int gaps, input int bready_delay);
        int cyc;
        int base;
        base = addr_idx(addr);
        bus.axi_awaddr  = addr;
        bus.axi_awlen   = 8'(len);
        bus.axi_awvalid = 1'b1;
        cyc = 0;
        while (!bus.axi_awready && cyc < TIMEOUT) begin step(); cyc++; end
        check("aw_ready", bus.axi_awready, 1'b1);
        step();
        bus.axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            bus.axi_wvalid = 1'b0;
            if (gaps != 0) repeat ($urandom_range(0, gaps)) step();
            bus.axi_wvalid = 1'b1;
            bus.axi_wdata  = wbuf[b];
            bus.axi_wlast  = (bad_last == -1) ? (b == len) : (bad_last >= 0 && b == bad_last);
            cyc = 0;
            while (!bus.axi_wready && cyc < TIMEOUT) begin step(); cyc++; end
            check("w_ready", bus.axi_wready, 1'b1);
            step();
            ref_mem[(base + b) % DEPTH] = wbuf[b];
        end
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast  = 1'b0;
        check("b_valid", bus.axi_bvalid, 1'b1);
        check("w_ready_off", bus.axi_wready, 1'b0);
        check("b_resp", bus.axi_bresp, (bad_last == -1) ? 2'b00 : 2'b10);
        repeat (bready_delay) begin
            step();
            check("b_hold", bus.axi_bvalid, 1'b1);
            check("aw_blocked", bus.axi_awready, 1'b0);
        end
        bus.axi_bready = 1'b1;
        step();
        bus.axi_bready = 1'b0;
        check("b_clear", bus.axi_bvalid, 1'b0);
        check("aw_reopen", bus.axi_awready, 1'b1);
    endtask

    // mode: 0 rready high, 1 alternating 1,0,1,..., 2 random.
    task automatic do_read(input logic [39:0] addr, input int len, input int mode);
        int cyc;
        int lat;
        int beat;
        int base;
        bit rr;
        bit hs;
        base = addr_idx(addr);
        bus.axi_araddr  = addr;
        bus.axi_arlen   = 8'(len);
        bus.axi_arvalid = 1'b1;
        cyc = 0;
        while (!bus.axi_arready && cyc < TIMEOUT) begin step(); cyc++; end
        check("ar_ready", bus.axi_arready, 1'b1);
        step();
        bus.axi_arvalid = 1'b0;
        lat = 1;
        while (!bus.axi_rvalid && lat < TIMEOUT) begin step(); lat++; end
        check("r_latency", lat, READ_LAT + 1);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < TIMEOUT) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (bus.axi_rvalid) begin
                check("r_data", bus.axi_rdata, ref_mem[(base + beat) % DEPTH]);
                check("r_last", bus.axi_rlast, beat == len);
            end
            bus.axi_rready = rr;
            hs = bus.axi_rvalid && rr;
            step();
            cyc++;
            if (hs) beat++;
        end
        bus.axi_rready = 1'b0;
        check("r_beats", beat, len + 1);
        check("r_done", bus.axi_rvalid, 1'b0);
        check("ar_reopen", bus.axi_arready, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [DW-1:0] x_word;
        logic [DW-1:0] y_word;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata  = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b0;

        repeat (3) step();
        check("rst_awready", bus.axi_awready, 1'b0);
        check("rst_arready", bus.axi_arready, 1'b0);
        check("rst_wready", bus.axi_wready, 1'b0);
        check("rst_bvalid", bus.axi_bvalid, 1'b0);
        check("rst_rvalid", bus.axi_rvalid, 1'b0);
        check("rst_rdata", bus.axi_rdata, '0);
        rst_n = 1'b1;
        step();
        check("post_rst_awready", bus.axi_awready, 1'b1);
        check("post_rst_arready", bus.axi_arready, 1'b1);

        // Fill the whole array so every later read has a known model value.
        for (int i = 0; i < 256; i++) wbuf[i] = rand_word();
        do_write(40'h0, 255, -1, 0, 0);

        wbuf[0] = {(DW/8){8'hA5}};
        do_write(40'h40, 0, -1, 0, 0);
        do_read(40'h40, 0, 0);

        for (int i = 0; i < 4; i++) wbuf[i] = DW'(i);
        do_write(40'h100, 3, -1, 0, 0);
        do_read(40'h100, 3, 1);

        for (int i = 0; i < 4; i++) wbuf[i] = rand_word();
        do_write(40'h200, 3, 1, 1, 0);
        do_read(40'h200, 3, 2);

        for (int i = 0; i < 3; i++) wbuf[i] = rand_word();
        do_write(40'h300, 2, -2, 0, 2);

        x_word = rand_word();
        y_word = rand_word();
        wbuf[0] = x_word;
        wbuf[1] = y_word;
        do_write(40'h1FE0, 1, -1, 0, 0);
        check("wrap_x_model", ref_mem[255], x_word);
        do_read(40'h0, 0, 0);
        do_read(40'h1FE0, 1, 0);

        for (int i = 0; i < 8; i++) wbuf[i] = rand_word();
        fork
            do_write(40'h000, 7, -1, 0, 5);
            do_read(40'h800, 7, 0);
        join

        // Reset in the middle of a 4-beat read.
        idx = addr_idx(40'h100);
        bus.axi_araddr  = 40'h100;
        bus.axi_arlen   = 8'd3;
        bus.axi_arvalid = 1'b1;
        step();
        bus.axi_arvalid = 1'b0;
        repeat (READ_LAT + 1) step();
        check("rst_mid_first", bus.axi_rvalid, 1'b1);
        bus.axi_rready = 1'b1;
        step();
        step();
        check("rst_mid_beat2", bus.axi_rdata, ref_mem[(idx + 2) % DEPTH]);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", bus.axi_rvalid, 1'b0);
        check("rst_mid_arready", bus.axi_arready, 1'b0);
        check("rst_mid_awready", bus.axi_awready, 1'b0);
        bus.axi_rready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_arready", bus.axi_arready, 1'b1);
        do_read(40'h100, 3, 0);

        for (int n = 0; n < 24; n++) begin
            logic [39:0] a;
            int len;
            int bad;
            a   = {$urandom, $urandom} & 40'hFF_FFFF_FFE0;
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wbuf[i] = rand_word();
                bad = -1;
                if ($urandom_range(0, 3) == 0) bad = (len > 0) ? int'($urandom_range(0, len - 1)) : -2;
                do_write(a, len, bad, 2, $urandom_range(0, 3));
            end else begin
                do_read(a, len, 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate (responder) memory model serving the DMA engine's 40-bit AXI initiator port.
- Accepts INCR bursts on AW/W/B and AR/R, backed by an internal DEPTH x DATA_WIDTH word array.
- Stands in for external DRAM in unit and system benches; synthesizable, with independent read and write channel FSMs.

Parameters:
- DATA_WIDTH, 256, beat width in bits; byte count must be a power of two.
- DEPTH, 256, number of memory words; power of two.
- READ_LAT, 2, cycles from AR handshake to the first rvalid beyond the minimum; 0 allowed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- axi_awaddr  in  40  write burst byte address
- axi_awlen  in  8  write beats minus one
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_wdata  in  DATA_WIDTH  write beat data
- axi_wlast  in  1  last write beat marker
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready
- axi_araddr  in  40  read burst byte address
- axi_arlen  in  8  read beats minus one
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_rdata  out  DATA_WIDTH  read beat data
- axi_rlast  out  1  last read beat
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Outputs are registered. While rst_n is low, all outputs are 0.
  - awready and arready rise on the first clk edge after rst_n deasserts.
  - Memory contents are not cleared by reset.
- Word index = addr[log2(DATA_WIDTH/8) +: log2(DEPTH)]. Higher bits are ignored, so indices wrap modulo DEPTH, both at the start address and mid-burst.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch index and awlen; awready=0 and wready=1 from the next cycle.
  - W_DATA: each wvalid&wready beat writes mem[idx], then idx+1 and beat+1.
  - The burst always ends after awlen+1 beats. bresp=SLVERR if wlast was seen before the final beat or is missing on it; otherwise OKAY. All awlen+1 beats are written regardless.
  - After the final beat: wready=0 and bvalid=1 on the next cycle.
  - W_RESP: hold bvalid and bresp until bready. Then bvalid=0 and awready=1 on the next cycle.
- Read FSM: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, latch index and arlen; arready=0. Enter R_WAIT with READ_LAT countdown, or go straight to R_DATA if READ_LAT=0.
  - R_DATA: rdata=mem[idx], rvalid=1, rlast=(beat==arlen).
  - First rvalid appears READ_LAT+1 cycles after the AR handshake cycle.
  - rdata, rlast and rvalid hold stable while rvalid&!rready.
  - On rvalid&rready: advance to the next word. With rready held high, one beat per cycle.
  - After the last beat is accepted: rvalid=0 and arready=1 on the next cycle.
- Channels: read and write are fully independent and may be active concurrently.
- Same-word collision: rdata is captured when the beat is loaded. A write committing in the same cycle as that load is not visible; the read returns old data.
- Only one outstanding burst per direction; no IDs, no interleaving. Burst type is INCR only; size is full width.
- Reset mid-burst: both FSMs return to IDLE immediately. The partial burst is abandoned, no response is issued, and words already written persist.

Test Plan:
- Write awaddr=0x40, awlen=0, wdata=0xA5A5..A5, wlast=1 -> bvalid=1 one cycle after the W beat, bresp=00. Then read araddr=0x40, arlen=0 -> rvalid 3 cycles after the AR handshake (READ_LAT=2), rdata=0xA5..A5, rlast=1.
- Write 4-beat burst at 0x100, data 0,1,2,3, bresp=00. Read back with rready pattern 1,0,1,0,1,0,1 -> beats 0..3 in order, rdata stable during stalls, rlast only on beat 3.
- awlen=3 with wlast asserted on beat 1 -> 4 beats accepted, bresp=10. Readback of 4 words returns all written data.
- DEPTH=256: awaddr=0x1FE0, awlen=1, data X,Y -> X at index 255, Y at index 0. Read araddr=0x0 -> Y.
- Concurrent 8-beat write at 0x000 and 8-beat read at 0x800 with bready held low 5 cycles -> read completes unaffected, bvalid held, awready stays 0 until bready.
- Assert rst_n low during beat 2 of a 4-beat read -> rvalid=0 immediately. arready=1 one cycle after release. A fresh read returns the previously written data.
